// File: rtl/mul_ctrl.sv
// rtl/mul_ctrl.sv - control FSM for the repeated-addition multiplier (optional limit: MUL_CTRL_TIMEOUT_EN)
module mul_ctrl #(
    parameter int CNT_W = 16
`ifdef MUL_CTRL_TIMEOUT_EN
    ,
    parameter logic [CNT_W-1:0] MAX_ITER = 16'hFFFF
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             eqz,
    output logic             ldA,
    output logic             ldB,
    output logic             clrP,
    output logic             ldP,
    output logic             decB,
    output logic             busy,
    output logic             done,
`ifdef MUL_CTRL_TIMEOUT_EN
    output logic             err,
`endif
    output logic [CNT_W-1:0] iter_count
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        ACCUM  = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t state;
    state_t state_next;

    // at_limit: the iteration budget is used up; accum_step: one P += A / B-- cycle
    logic at_limit;
    logic accum_step;

`ifdef MUL_CTRL_TIMEOUT_EN
    assign at_limit = (iter_count == MAX_ITER);
`else
    assign at_limit = 1'b0;
`endif

    assign accum_step = (state == ACCUM) && !eqz && !at_limit;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; start only matters in IDLE and DONE
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = LOAD_A;
            LOAD_A:  state_next = LOAD_B;
            LOAD_B:  state_next = ACCUM;
            ACCUM:   if (eqz || at_limit) state_next = DONE;
            DONE:    if (!start) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode: Moore strobes plus eqz-gated accumulate strobes
    always_comb begin
        ldA  = 1'b0;
        ldB  = 1'b0;
        clrP = 1'b0;
        ldP  = 1'b0;
        decB = 1'b0;
        busy = (state != IDLE);
        done = 1'b0;
        case (state)
            LOAD_A: ldA = 1'b1;
            LOAD_B: begin
                ldB  = 1'b1;
                clrP = 1'b1;
            end
            ACCUM: begin
                ldP  = accum_step;
                decB = accum_step;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Iteration counter: cleared when A is loaded, saturating count of ldP strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iter_count <= '0;
        end else if (state == LOAD_A) begin
            iter_count <= '0;
        end else if (accum_step && (iter_count != {CNT_W{1'b1}})) begin
            iter_count <= iter_count + CNT_W'(1);
        end
    end

`ifdef MUL_CTRL_TIMEOUT_EN
    // Error flag: set when the iteration limit cuts an operation short, cleared on the next load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (state == LOAD_A) begin
            err <= 1'b0;
        end else if ((state == ACCUM) && !eqz && at_limit) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mul_ctrl.sv
// tb/tb_mul_ctrl.sv - table-driven bench for mul_ctrl with a behavioural A/B/P datapath
module tb_mul_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        eqz;
    logic        ldA, ldB, clrP, ldP, decB, busy, done;
    logic [15:0] iter_count;
`ifdef MUL_CTRL_TIMEOUT_EN
    logic        err;
`endif

    logic [15:0] data_in = 16'h0;
    logic [15:0] a_reg = 16'h0;
    logic [15:0] b_reg = 16'h0;
    logic [15:0] p_reg = 16'h0;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    assign eqz = (b_reg == 16'h0);

    // Datapath: operand registers, down-counter and accumulator driven by the strobes
    always @(posedge clk) begin
        if (ldA)  a_reg <= data_in;
        if (ldB)  b_reg <= data_in;
        else if (decB) b_reg <= b_reg - 16'd1;
        if (clrP) p_reg <= 16'h0;
        else if (ldP) p_reg <= p_reg + a_reg;
    end

`ifdef MUL_CTRL_TIMEOUT_EN
    mul_ctrl #(.CNT_W(16), .MAX_ITER(16'd300)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .eqz(eqz),
        .ldA(ldA), .ldB(ldB), .clrP(clrP), .ldP(ldP), .decB(decB),
        .busy(busy), .done(done), .err(err), .iter_count(iter_count)
    );
`else
    mul_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .eqz(eqz),
        .ldA(ldA), .ldB(ldB), .clrP(clrP), .ldP(ldP), .decB(decB),
        .busy(busy), .done(done), .iter_count(iter_count)
    );
`endif

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_p;
        int          exp_n;
        int          hold;
    } vec_t;

    // One multiply starting from IDLE at a negedge; ends at a negedge back in IDLE
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_p, input int exp_n, input int hold);
        int cyc = 0;
        int n_ldp = 0, first_ldp = -1, last_ldp = -1, done_cyc = -1;
        int ldA_cyc = -1, ldA_cnt = 0, ldB_cyc = -1, clrP_cyc = -1;
        int busy_bad = 0, excl_bad = 0, hold_bad = 0;
        start = 1'b1;
        @(posedge clk);
        while (done_cyc < 0 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (ldA) begin ldA_cnt++; ldA_cyc = cyc; end
            if (ldB)  ldB_cyc = cyc;
            if (clrP) clrP_cyc = cyc;
            if (ldP) begin
                n_ldp++;
                if (first_ldp < 0) first_ldp = cyc;
                last_ldp = cyc;
            end
            if (ldP != decB) excl_bad++;
            if ((int'(ldA) + int'(ldB) + int'(ldP)) > 1 || (clrP && ldP)) excl_bad++;
            if (!busy) busy_bad++;
            if (done) done_cyc = cyc;
            data_in = (cyc == 1) ? a : (cyc == 2) ? b : 16'hDEAD;
            if (hold == 0 && cyc == 1) start = 1'b0;
        end
        check("ldA_cycle", ldA_cyc, 1);
        check("ldB_cycle", ldB_cyc, 2);
        check("clrP_cycle", clrP_cyc, 2);
        check("ldP_count", n_ldp, exp_n);
        check("first_ldP", first_ldp, (exp_n == 0) ? -1 : 3);
        check("last_ldP", last_ldp, (exp_n == 0) ? -1 : exp_n + 2);
        check("done_cycle", done_cyc, exp_n + 4);
        check("busy_gap", busy_bad, 0);
        check("strobe_excl", excl_bad, 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!done || !busy || ldA) hold_bad++;
            if (ldA) ldA_cnt++;
        end
        if (hold > 0) check("held_start_stays_done", hold_bad, 0);
        check("single_ldA", ldA_cnt, 1);
        start = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("product", p_reg, exp_p);
        check("iter_count", iter_count, exp_n);
    endtask

    vec_t vecs[8];

    initial begin
        int cnt;
        int cyc;
        int idle_bad;
        vecs[0] = '{16'd17,    16'd5,   16'd85,     5,   0};
        vecs[1] = '{16'd1234,  16'd0,   16'd0,      0,   0};
        vecs[2] = '{16'd3,     16'd4,   16'd12,     4,   0};
        vecs[3] = '{16'd7,     16'd2,   16'd14,     2,   0};
        vecs[4] = '{16'd1,     16'd1,   16'd1,      1,   10};
        vecs[5] = '{16'd0,     16'd3,   16'd0,      3,   0};
        vecs[6] = '{16'd255,   16'd255, 16'hFE01,   255, 0};
        vecs[7] = '{16'hFFFF,  16'd2,   16'hFFFE,   2,   0};

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_outputs", {ldA, ldB, clrP, ldP, decB, busy, done}, 0);
        check("reset_iter", iter_count, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", {ldA, ldB, clrP, ldP, decB, busy, done}, 0);

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].exp_p, vecs[i].exp_n, vecs[i].hold);
        end

        // Asynchronous reset in ACCUM after three iterations of B=8
        start = 1'b1;
        @(posedge clk);
        cnt = 0;
        cyc = 0;
        while (cnt < 3 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) start = 1'b0;
            data_in = (cyc == 1) ? 16'd9 : (cyc == 2) ? 16'd8 : 16'hDEAD;
            if (ldP) cnt++;
        end
        check("third_ldP_cycle", cyc, 5);
        check("iter_mid_accum", iter_count, 2);
        #1 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {ldA, ldB, clrP, ldP, decB, busy, done}, 0);
        check("async_reset_iter", iter_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_bad = 0;
        repeat (5) begin
            @(negedge clk);
            if ({ldA, ldB, clrP, ldP, decB, busy, done} != 7'd0 || iter_count != 16'd0) idle_bad++;
        end
        check("idle_after_abort", idle_bad, 0);
        run_op(16'd6, 16'd3, 16'd18, 3, 0);

`ifdef MUL_CTRL_TIMEOUT_EN
        run_op(16'd2, 16'd400, 16'd600, 300, 0);
        check("timeout_err", err, 1);
        run_op(16'd5, 16'd2, 16'd10, 2, 0);
        check("err_cleared", err, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
